// File: rtl/btn_event_pkg.sv
// -----------------------------------------------------------------------------
// btn_event_pkg
// Shared definitions for the button event decoder:
//   - state_t    : one-hot FSM state encoding (5 bits)
//   - TICKS_MIN  : smallest legal value for any tick threshold
//   - ticks_legal: elaboration-time range check for a tick threshold against
//                  the width of the shared interval counter
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package btn_event_pkg;

    localparam int unsigned STATE_W = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 5'b00001,
        ST_PRESS1 = 5'b00010,
        ST_WAIT2  = 5'b00100,
        ST_PRESS2 = 5'b01000,
        ST_LONG   = 5'b10000
    } state_t;

    localparam int unsigned TICKS_MIN = 2;

    // A threshold must be reachable by the saturating counter, which tops out
    // at 2^cnt_w-1, and must be at least 2 so "threshold-1" is a real count.
    function automatic logic ticks_legal(input int unsigned ticks,
                                         input int unsigned cnt_w);
        longint ticks_max;
        ticks_max = (longint'(1) << cnt_w) - 1;
        return (longint'(ticks) >= longint'(TICKS_MIN)) &&
               (longint'(ticks) <= ticks_max);
    endfunction

endpackage

// File: rtl/level_edge_detect.sv
// -----------------------------------------------------------------------------
// level_edge_detect
// Two-flop sample stage for an already-synchronous level, with combinational
// rise/fall strobes derived from the two stages.
// Ports:
//   sysclk  in  : clock
//   reset_n in  : asynchronous reset, active-low (both stages reset to 0)
//   din     in  : level to sample
//   lvl_q   out : first sample stage
//   rise    out : lvl_q & ~lvl_qq
//   fall    out : ~lvl_q & lvl_qq
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module level_edge_detect (
    input  logic sysclk,
    input  logic reset_n,
    input  logic din,
    output logic lvl_q,
    output logic rise,
    output logic fall
);

    logic lvl_qq;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_q  <= 1'b0;
            lvl_qq <= 1'b0;
        end else begin
            lvl_q  <= din;
            lvl_qq <= lvl_q;
        end
    end

    assign rise = lvl_q & ~lvl_qq;
    assign fall = ~lvl_q & lvl_qq;

endmodule

// File: rtl/btn_event_decoder.sv
// -----------------------------------------------------------------------------
// btn_event_decoder
// Turns a debounced button level into press/release pulses, single click,
// double click and long-press events. All event outputs are registered
// one-cycle pulses; held_o is a level.
// Parameters:
//   CNT_W        : width of the shared interval counter
//   LONG_TICKS   : held cycles that qualify as a long press
//   DCLICK_TICKS : max released gap between the presses of a double click
//   ACTIVE_LOW   : 1 when btn_i=0 means pressed
// Ports:
//   sysclk    in  : clock
//   reset_n   in  : asynchronous reset, active-low
//   btn_i     in  : debounced button level, synchronous to sysclk
//   press_o   out : pulse on press edge
//   release_o out : pulse on release edge
//   click_o   out : pulse when a single click is resolved
//   dclick_o  out : pulse when a double click is resolved
//   long_o    out : pulse when the long-press threshold is reached
//   held_o    out : level, 1 while pressed
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module btn_event_decoder
    import btn_event_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned LONG_TICKS   = 50000,
    parameter int unsigned DCLICK_TICKS = 20000,
    parameter logic        ACTIVE_LOW   = 1'b1
) (
    input  logic sysclk,
    input  logic reset_n,
    input  logic btn_i,
    output logic press_o,
    output logic release_o,
    output logic click_o,
    output logic dclick_o,
    output logic long_o,
    output logic held_o
);

    if (!ticks_legal(LONG_TICKS, CNT_W)) begin : g_bad_long_ticks
        $error("btn_event_decoder: LONG_TICKS out of range for CNT_W");
    end
    if (!ticks_legal(DCLICK_TICKS, CNT_W)) begin : g_bad_dclick_ticks
        $error("btn_event_decoder: DCLICK_TICKS out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic       pressed;
    logic       lvl_q;
    logic       rise;
    logic       fall;
    state_t     state_q;
    state_t     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic       click_d;
    logic       dclick_d;
    logic       long_d;

    assign pressed = btn_i ^ ACTIVE_LOW;

    level_edge_detect u_edge (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .din     (pressed),
        .lvl_q   (lvl_q),
        .rise    (rise),
        .fall    (fall)
    );

    assign held_o = lvl_q;

    // Edges take priority over timeouts in every state, so a release on the
    // threshold cycle or a second press on the last gap cycle is honoured.
    always_comb begin
        state_d  = state_q;
        click_d  = 1'b0;
        dclick_d = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (fall) begin
                    state_d = ST_WAIT2;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (rise) begin
                    state_d = ST_PRESS2;
                end else if (cnt_q == DCLICK_LAST) begin
                    state_d = ST_IDLE;
                    click_d = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    state_d  = ST_IDLE;
                    dclick_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The interval counter restarts on every state change so each state
    // measures time since it was entered; it saturates instead of wrapping.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
            click_o   <= 1'b0;
            dclick_o  <= 1'b0;
            long_o    <= 1'b0;
        end else begin
            press_o   <= rise;
            release_o <= fall;
            click_o   <= click_d;
            dclick_o  <= dclick_d;
            long_o    <= long_d;
        end
    end

endmodule

// File: tb/tb_btn_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_btn_event_decoder
// Directed, table-driven bench for btn_event_decoder with CNT_W=8,
// LONG_TICKS=20, DCLICK_TICKS=10, ACTIVE_LOW=1. Cycle k is the negedge at
// which outputs are sampled and then btn_i for that cycle is driven.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_btn_event_decoder;

    logic sysclk = 1'b0;
    logic reset_n;
    logic btn_i;
    logic press_o, release_o, click_o, dclick_o, long_o, held_o;

    int checks = 0;
    int errors = 0;

    always #5 sysclk = ~sysclk;

    btn_event_decoder #(
        .CNT_W        (8),
        .LONG_TICKS   (20),
        .DCLICK_TICKS (10),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .btn_i     (btn_i),
        .press_o   (press_o),
        .release_o (release_o),
        .click_o   (click_o),
        .dclick_o  (dclick_o),
        .long_o    (long_o),
        .held_o    (held_o)
    );

    // Stimulus: press p1 cycles, release gap cycles, press p2 cycles (p2=0
    // means single press), then stay released. Expected values are pulse
    // counts and the cycle index of the last pulse (-1 when none).
    typedef struct {
        string name;
        int p1;
        int gap;
        int p2;
        int press_n;  int press_last;
        int rel_n;    int rel_last;
        int click_n;  int click_last;
        int dclick_n; int dclick_last;
        int long_n;   int long_last;
        int held_n;
    } vec_t;

    vec_t vecs[8];

    int press_n, press_last, rel_n, rel_last, click_n, click_last;
    int dclick_n, dclick_last, long_n, long_last, held_n, excl_n;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_record();
        press_n = 0;  press_last = -1;
        rel_n = 0;    rel_last = -1;
        click_n = 0;  click_last = -1;
        dclick_n = 0; dclick_last = -1;
        long_n = 0;   long_last = -1;
        held_n = 0;   excl_n = 0;
    endtask

    task automatic record(input int k);
        if (press_o)   begin press_n++;  press_last = k;  end
        if (release_o) begin rel_n++;    rel_last = k;    end
        if (click_o)   begin click_n++;  click_last = k;  end
        if (dclick_o)  begin dclick_n++; dclick_last = k; end
        if (long_o)    begin long_n++;   long_last = k;   end
        if (held_o)    held_n++;
        if ((int'(click_o) + int'(dclick_o) + int'(long_o)) > 1) excl_n++;
    endtask

    task automatic apply_stimulus(input vec_t v);
        int  n;
        bit  pr;
        reset_n = 1'b0;
        btn_i   = 1'b1;
        repeat (2) @(negedge sysclk);
        reset_n = 1'b1;
        clear_record();
        n = v.p1 + v.gap + v.p2 + 30;
        for (int k = 0; k < n; k++) begin
            @(negedge sysclk);
            record(k);
            pr = (k < v.p1) ||
                 ((v.p2 > 0) && (k >= v.p1 + v.gap) && (k < v.p1 + v.gap + v.p2));
            btn_i = pr ? 1'b0 : 1'b1;
        end
        check_output({v.name, " press count"},   press_n,     v.press_n);
        check_output({v.name, " press last"},    press_last,  v.press_last);
        check_output({v.name, " release count"}, rel_n,       v.rel_n);
        check_output({v.name, " release last"},  rel_last,    v.rel_last);
        check_output({v.name, " click count"},   click_n,     v.click_n);
        check_output({v.name, " click last"},    click_last,  v.click_last);
        check_output({v.name, " dclick count"},  dclick_n,    v.dclick_n);
        check_output({v.name, " dclick last"},   dclick_last, v.dclick_last);
        check_output({v.name, " long count"},    long_n,      v.long_n);
        check_output({v.name, " long last"},     long_last,   v.long_last);
        check_output({v.name, " held cycles"},   held_n,      v.held_n);
        check_output({v.name, " exclusive"},     excl_n,      0);
    endtask

    initial begin
        vecs[0] = '{"single_click",   5,  0,  0, 1,  2, 1,  7, 1, 17, 0, -1, 0, -1,  5};
        vecs[1] = '{"double_click",   5,  4,  5, 2, 11, 2, 16, 0, -1, 1, 16, 0, -1, 10};
        vecs[2] = '{"long_press",    30,  0,  0, 1,  2, 1, 32, 0, -1, 0, -1, 1, 22, 30};
        vecs[3] = '{"rise_wins",      5, 10,  5, 2, 17, 2, 22, 0, -1, 1, 22, 0, -1, 10};
        vecs[4] = '{"gap_expired",    5, 11,  5, 2, 18, 2, 23, 2, 33, 0, -1, 0, -1, 10};
        vecs[5] = '{"long_second",    5,  4, 25, 2, 11, 2, 36, 0, -1, 0, -1, 1, 31, 30};
        vecs[6] = '{"fall_at_thresh",20,  0,  0, 1,  2, 1, 22, 1, 32, 0, -1, 0, -1, 20};
        vecs[7] = '{"long_at_thresh",21,  0,  0, 1,  2, 1, 23, 0, -1, 0, -1, 1, 22, 21};

        // Reset state, with the button pressed so held_o cannot follow it.
        reset_n = 1'b0;
        btn_i   = 1'b0;
        #1;
        check_output("reset outputs", int'({press_o, release_o, click_o, dclick_o, long_o, held_o}), 0);
        repeat (3) @(negedge sysclk);
        check_output("reset outputs held", int'({press_o, release_o, click_o, dclick_o, long_o, held_o}), 0);

        for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);

        // Reset while in WAIT2, right as release_o is high; no pending click
        // may escape, and a button held through reset release yields a press.
        reset_n = 1'b0;
        btn_i   = 1'b1;
        repeat (2) @(negedge sysclk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge sysclk);
            if (k == 7) check_output("release before reset", int'(release_o), 1);
            btn_i = (k < 5) ? 1'b0 : 1'b1;
        end
        reset_n = 1'b0;
        #1;
        check_output("async reset outputs", int'({press_o, release_o, click_o, dclick_o, long_o, held_o}), 0);
        btn_i = 1'b0;
        repeat (3) @(negedge sysclk);
        check_output("reset pressed outputs", int'({press_o, release_o, click_o, dclick_o, long_o, held_o}), 0);
        reset_n = 1'b1;
        clear_record();
        for (int m = 1; m <= 15; m++) begin
            @(negedge sysclk);
            record(m);
            if (m == 1) check_output("held after reset", int'(held_o), 1);
            if (m == 1) check_output("no press at 1", int'(press_o), 0);
        end
        check_output("post-reset press count", press_n, 1);
        check_output("post-reset press cycle", press_last, 2);
        check_output("post-reset click count", click_n, 0);
        check_output("post-reset release count", rel_n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_event_decoder.md
# btn_event_decoder

Consumes the clean, debounced level produced by the board's button debouncer and turns it into discrete user events: press/release pulses, single click, double click and long press. It sits between the debouncer and the application control logic, so the application never times button levels itself. All outputs are registered single-cycle pulses, except `held_o`, which is a level.

## Interface
Parameters:
- `CNT_W`, 16: width of the shared interval counter.
- `LONG_TICKS`, 16'd50000: number of held cycles that qualify as a long press. Legal range is 2 to 2^CNT_W-1.
- `DCLICK_TICKS`, 16'd20000: maximum released gap, in cycles, between the two presses of a double click. Legal range is 2 to 2^CNT_W-1.
- `ACTIVE_LOW`, 1: when 1, `btn_i`=0 means pressed. This matches the debouncer's idle-high output.

Ports:
- `sysclk` in 1: the single clock.
- `reset_n` in 1: asynchronous reset, active-low.
- `btn_i` in 1: debounced button level, already synchronous to `sysclk`.
- `press_o` out 1: one-cycle pulse on a press edge.
- `release_o` out 1: one-cycle pulse on a release edge.
- `click_o` out 1: one-cycle pulse when a single short click is resolved.
- `dclick_o` out 1: one-cycle pulse when a double click is resolved.
- `long_o` out 1: one-cycle pulse when the long-press threshold is reached.
- `held_o` out 1: level, 1 while the button is pressed (normalised).

## Operation
- Normalise the input: p = `btn_i` XOR `ACTIVE_LOW`.
- Sample p into `lvl_q`, then into `lvl_qq`.
- Edge detection:
  - rise = `lvl_q` & ~`lvl_qq`
  - fall = ~`lvl_q` & `lvl_qq`
- On reset, `lvl_q` and `lvl_qq` are 0 (released). Holding the button through reset therefore produces one press edge after reset.
- Counter `cnt`:
  - cleared to 0 on every state change;
  - otherwise incremented each cycle;
  - saturates at 2^CNT_W-1 and never wraps.
- FSM states: IDLE, PRESS1, WAIT2, PRESS2, LONG. Transitions:
  - IDLE: rise → PRESS1.
  - PRESS1:
    - fall → WAIT2;
    - else if `cnt`==LONG_TICKS-1 → LONG and pulse `long_o`.
  - WAIT2:
    - rise → PRESS2;
    - else if `cnt`==DCLICK_TICKS-1 → IDLE and pulse `click_o`.
    - If rise and timeout occur in the same cycle, rise wins: no click, go to PRESS2.
  - PRESS2:
    - fall → IDLE and pulse `dclick_o`;
    - else if `cnt`==LONG_TICKS-1 → LONG and pulse `long_o`. No `dclick_o` follows.
  - LONG: fall → IDLE. No click of any kind is reported.
- `press_o` and `release_o` pulse on every rise and fall, in every state, independent of the FSM.
- `held_o` = `lvl_q`, registered.
- Mutual exclusion: at most one of `click_o`, `dclick_o`, `long_o` is high in any cycle.
- A fall in PRESS1 on the same cycle as the long-press threshold resolves as fall: go to WAIT2, no `long_o`.
- Reset mid-operation: the FSM returns to IDLE, `cnt` to 0, and all outputs to 0 on the next edge of `reset_n` low. No pending click is emitted.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE and `cnt` to 0.
- Latency from the first `sysclk` edge that samples a changed `btn_i`:
  - `press_o` and `release_o` assert 2 cycles later;
  - `held_o` asserts 1 cycle later.
- `long_o` asserts exactly LONG_TICKS cycles after the cycle in which `press_o` asserts.
- `click_o` asserts DCLICK_TICKS cycles after `release_o`, when no second press occurs.
- `dclick_o` asserts in the same cycle as the second `release_o`.
- Every pulse output is high for exactly 1 cycle.

## Structure
- Package `btn_event_pkg` holds:
  - the FSM state localparams, one-hot, 5 bits;
  - the range-check constants for the legal tick values.
- Sub-module `level_edge_detect` holds the two-flop sample stage and the rise/fall outputs. The team reuses it elsewhere.
- The top level contains the FSM, the counter and the output registers.
- Illegal tick parameter values are rejected at elaboration.

## Test plan
All scenarios use CNT_W=8, LONG_TICKS=20, DCLICK_TICKS=10, ACTIVE_LOW=1.
- Press for 5 cycles, then release and stay idle for 15 cycles → `press_o` and `release_o` pulse once each; `click_o` pulses 10 cycles after `release_o`; no `dclick_o` or `long_o`.
- Press 5, release 4, press 5, release → `dclick_o` coincides with the second `release_o`; no `click_o`.
- Press for 30 cycles → `long_o` 20 cycles after `press_o`; `held_o` is high throughout; release gives `release_o` only, with no click.
- Press 5, then release timed so the second rise lands exactly at `cnt`=9 in WAIT2 → rise wins; the FSM reaches PRESS2; no `click_o`.
- Second press held 25 cycles → `long_o` fires and `dclick_o` never fires.
- Assert `reset_n`=0 during WAIT2 → all outputs are 0 immediately; `click_o` is never emitted. Hold `btn_i`=0 through reset release → one `press_o` 2 cycles after reset deassertion.
